// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: op encoding,
// PC branch codes and the constant jump/branch target table.
package branch_pkg;

    localparam int D_DEF = 12;
    localparam int L_DEF = 5;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_BRT  = 3'b001,
        OP_BRF  = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101,
        OP_HALT = 3'b110,
        OP_RSVD = 3'b111
    } br_op_t;

    localparam logic [1:0] BR_SEQ    = 2'b00;
    localparam logic [1:0] BR_T      = 2'b01;
    localparam logic [1:0] BR_F      = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

    // Target table: entry i holds 12'h010 + 16*i.
    localparam logic [D_DEF-1:0] TGT_LUT [2**L_DEF] = '{
        12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060, 12'h070, 12'h080,
        12'h090, 12'h0a0, 12'h0b0, 12'h0c0, 12'h0d0, 12'h0e0, 12'h0f0, 12'h100,
        12'h110, 12'h120, 12'h130, 12'h140, 12'h150, 12'h160, 12'h170, 12'h180,
        12'h190, 12'h1a0, 12'h1b0, 12'h1c0, 12'h1d0, 12'h1e0, 12'h1f0, 12'h200
    };

    // The PC port is 3 bits wide; the top bit is always zero.
    function automatic logic [2:0] br_code(input logic [1:0] code);
        return {1'b0, code};
    endfunction

endpackage

// File: rtl/branch_ctrl_ras_stack.sv
// Circular return-address stack with saturating occupancy count.
// The pre-pop top entry is presented combinationally.
module ras_stack
    import branch_pkg::*;
#(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D-1:0]               din,
    output logic [D-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [D-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] ptr_reg;
    logic [CW-1:0] count_reg;

    // When full, ptr points at the oldest entry, so a push overwrites it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && (ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (count_reg != CW'(DEPTH)) begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop) begin
            ptr_reg <= ptr_reg - PW'(1);
            if (count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign top   = mem_reg[ptr_reg - PW'(1)];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/branch_ctrl.sv
// Branch-op decode feeding the PC: target LUT, return-address stack and
// sticky overflow/underflow/halt status.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int D     = 12,
    parameter int L     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   br_op,
    input  logic [L-1:0] lut_idx,
    input  logic [D-1:0] pc_in,
    output logic [2:0]   branch,
    output logic [D-1:0] target,
    output logic         ras_empty,
    output logic         ras_full,
    output logic         ras_ovf,
    output logic         ras_unf,
    output logic         halted
);

    localparam int CW = $clog2(DEPTH+1);

    logic [D-1:0]  lut_tgt;
    logic [D-1:0]  ras_top;
    logic [CW-1:0] ras_count;
    logic          ras_push;
    logic          ras_pop;
    logic          stk_full;
    logic          stk_empty;
    logic          set_ovf;
    logic          set_unf;
    logic          set_halt;
    logic          ras_ovf_reg;
    logic          ras_unf_reg;
    logic          halted_reg;

    assign lut_tgt = D'(TGT_LUT[lut_idx]);

    ras_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_in + D'(1)),
        .top   (ras_top),
        .count (ras_count),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Once halted, every op is ignored and the PC is parked on pc_in.
    always_comb begin
        branch   = br_code(BR_SEQ);
        target   = '0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        set_halt = 1'b0;
        if (halted_reg) begin
            branch = br_code(BR_ALWAYS);
            target = pc_in;
        end else begin
            case (br_op_t'(br_op))
                OP_BRT: begin
                    branch = br_code(BR_T);
                    target = lut_tgt;
                end
                OP_BRF: begin
                    branch = br_code(BR_F);
                    target = lut_tgt;
                end
                OP_JMP: begin
                    branch = br_code(BR_ALWAYS);
                    target = lut_tgt;
                end
                OP_CALL: begin
                    branch   = br_code(BR_ALWAYS);
                    target   = lut_tgt;
                    ras_push = 1'b1;
                    set_ovf  = stk_full;
                end
                OP_RET: begin
                    if (stk_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        branch  = br_code(BR_ALWAYS);
                        target  = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                OP_HALT: begin
                    branch   = br_code(BR_ALWAYS);
                    target   = pc_in;
                    set_halt = 1'b1;
                end
                default: begin
                    branch = br_code(BR_SEQ);
                    target = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ovf_reg <= 1'b0;
            ras_unf_reg <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            if (set_ovf)  ras_ovf_reg <= 1'b1;
            if (set_unf)  ras_unf_reg <= 1'b1;
            if (set_halt) halted_reg  <= 1'b1;
        end
    end

    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
    assign ras_ovf   = ras_ovf_reg;
    assign ras_unf   = ras_unf_reg;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  br_op = 3'd0;
    logic [4:0]  lut_idx = 5'd0;
    logic [11:0] pc_in = 12'd0;
    logic [2:0]  branch;
    logic [11:0] target;
    logic        ras_empty, ras_full, ras_ovf, ras_unf, halted;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [11:0] m_ras [$];
    bit m_ovf = 0, m_unf = 0, m_halt = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.D(12), .L(5), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .br_op(br_op), .lut_idx(lut_idx), .pc_in(pc_in),
        .branch(branch), .target(target), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .halted(halted)
    );

    function automatic logic [11:0] m_lut(input logic [4:0] idx);
        return 12'h010 + 12'(16 * int'(idx));
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state update, mirrored at each active edge.
    always @(posedge clk) begin
        if (reset) begin
            m_ras.delete();
            m_ovf = 0; m_unf = 0; m_halt = 0;
        end else if (!m_halt) begin
            case (br_op)
                3'd4: begin
                    if (m_ras.size() == 4) begin
                        m_ovf = 1;
                        void'(m_ras.pop_front());
                    end
                    m_ras.push_back(pc_in + 12'd1);
                end
                3'd5: begin
                    if (m_ras.size() == 0) m_unf = 1;
                    else void'(m_ras.pop_back());
                end
                3'd6: m_halt = 1;
                default: ;
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            int eb;
            int et;
            eb = 0; et = 0;
            if (m_halt) begin
                eb = 3; et = pc_in;
            end else begin
                case (br_op)
                    3'd1: begin eb = 1; et = m_lut(lut_idx); end
                    3'd2: begin eb = 2; et = m_lut(lut_idx); end
                    3'd3, 3'd4: begin eb = 3; et = m_lut(lut_idx); end
                    3'd5: if (m_ras.size() != 0) begin eb = 3; et = m_ras[$]; end
                    3'd6: begin eb = 3; et = pc_in; end
                    default: ;
                endcase
            end
            cmp("m_branch", branch, eb);
            cmp("m_target", target, et);
            cmp("m_empty", ras_empty, m_ras.size() == 0);
            cmp("m_full", ras_full, m_ras.size() == 4);
            cmp("m_ovf", ras_ovf, m_ovf);
            cmp("m_unf", ras_unf, m_unf);
            cmp("m_halted", halted, m_halt);
        end
    end

    task automatic drive(input logic [2:0] op, input logic [4:0] idx, input logic [11:0] pc);
        @(posedge clk);
        #1;
        br_op = op; lut_idx = idx; pc_in = pc;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1; br_op = 3'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Reset state
        cmp("rst_branch", branch, 0);
        cmp("rst_target", target, 0);
        cmp("rst_empty", ras_empty, 1);
        cmp("rst_full", ras_full, 0);
        cmp("rst_sticky", {ras_ovf, ras_unf, halted}, 0);

        // LUT-resolved branches
        drive(3'd1, 5'd3, 12'h000); cmp("brt_branch", branch, 1); cmp("brt_target", target, 12'h040);
        drive(3'd2, 5'd3, 12'h000); cmp("brf_branch", branch, 2); cmp("brf_target", target, 12'h040);
        drive(3'd3, 5'd3, 12'h000); cmp("jmp_branch", branch, 3); cmp("jmp_target", target, 12'h040);
        drive(3'd3, 5'd0, 12'h000); cmp("jmp_idx0", target, 12'h010);
        drive(3'd3, 5'd31, 12'h000); cmp("jmp_idx31", target, 12'h200);
        drive(3'd7, 5'd3, 12'h055); cmp("op7_branch", branch, 0); cmp("op7_target", target, 0);

        // Single call/return
        drive(3'd4, 5'd5, 12'h010); cmp("call_target", target, 12'h060);
        drive(3'd5, 5'd0, 12'h045); cmp("ret_branch", branch, 3); cmp("ret_target", target, 12'h011);
        drive(3'd0, 5'd0, 12'h046); cmp("ret_empty", ras_empty, 1);

        // Return-address wrap
        drive(3'd4, 5'd1, 12'hfff);
        drive(3'd5, 5'd0, 12'h020); cmp("wrap_target", target, 12'h000);

        // Overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            drive(3'd4, 5'(i), 12'(i));
            if (i == 5) cmp("full_after4", ras_full, 1);
        end
        drive(3'd5, 5'd0, 12'h030); cmp("ovf_set", ras_ovf, 1); cmp("ret1", target, 6);
        drive(3'd5, 5'd0, 12'h031); cmp("ret2", target, 5);
        drive(3'd5, 5'd0, 12'h032); cmp("ret3", target, 4);
        drive(3'd5, 5'd0, 12'h033); cmp("ret4", target, 3);
        drive(3'd0, 5'd0, 12'h034); cmp("drain_empty", ras_empty, 1);

        // Underflow
        drive(3'd5, 5'd0, 12'h035); cmp("unf_branch", branch, 0); cmp("unf_target", target, 0);
        drive(3'd0, 5'd0, 12'h036); cmp("unf_set", ras_unf, 1);
        drive(3'd0, 5'd0, 12'h037);
        drive(3'd0, 5'd0, 12'h038); cmp("unf_sticky", ras_unf, 1);

        // Halt freezes the PC and the stack
        drive(3'd4, 5'd2, 12'h018);
        drive(3'd6, 5'd0, 12'h020); cmp("halt_branch", branch, 3); cmp("halt_target", target, 12'h020);
        drive(3'd3, 5'd3, 12'h021); cmp("halted_set", halted, 1);
        cmp("halt_jmp_branch", branch, 3); cmp("halt_jmp_target", target, 12'h021);
        drive(3'd5, 5'd0, 12'h022); cmp("halt_ret_target", target, 12'h022);
        drive(3'd0, 5'd0, 12'h023); cmp("halt_ras_frozen", ras_empty, 0);

        // Reset clears everything
        pulse_reset();
        cmp("rst2_halted", halted, 0);
        cmp("rst2_empty", ras_empty, 1);
        cmp("rst2_unf", ras_unf, 0);
        drive(3'd5, 5'd0, 12'h040); cmp("rst2_ret_branch", branch, 0);
        drive(3'd0, 5'd0, 12'h041);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
